// File: rtl/multiplicador_booth_nbits_pkg.sv
// Shared state encoding and Booth recoding constants for the radix-2 Booth multiplier.
package multiplicador_booth_nbits_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth pair is {q[0], q[-1]}: 01 adds the multiplicand, 10 subtracts it.
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/multiplicador_booth_nbits_sumador.sv
// NBITS-wide two's-complement adder/subtractor: oS = iX + iY (iOp=0) or iX - iY (iOp=1).
module sumadorRestadorNBits #(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0] iX,
    input  logic [NBITS-1:0] iY,
    input  logic             iOp,
    output logic [NBITS-1:0] oS,
    output logic             oCout,
    output logic             oOverflow
);

    logic [NBITS-1:0] y_eff;

    assign y_eff = iY ^ {NBITS{iOp}};
    assign {oCout, oS} = {1'b0, iX} + {1'b0, y_eff} + {{NBITS{1'b0}}, iOp};

    // Signed overflow: both addends share a sign that the result does not.
    assign oOverflow = (iX[NBITS-1] == y_eff[NBITS-1]) && (oS[NBITS-1] != iX[NBITS-1]);

endmodule

// File: rtl/multiplicador_booth_nbits.sv
// Sequential signed radix-2 Booth multiplier: 2*NBITS product NBITS+1 cycles after a start.
module multiplicador_booth_nbits
    import multiplicador_booth_nbits_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [NBITS-1:0]     iMultiplicando,
    input  logic [NBITS-1:0]     iMultiplicador,
    output logic [2*NBITS-1:0]   oProducto,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int CW = $clog2(NBITS + 1);

    state_t             state;
    logic [NBITS-1:0]   acc;
    logic [NBITS-1:0]   mult_q;
    logic [NBITS-1:0]   mcand;
    logic               q_m1;
    logic [CW-1:0]      count;
    logic [2*NBITS-1:0] product;
    logic               busy;
    logic               done;

    logic [1:0]         pair;
    logic               do_sub;
    logic               use_adder;
    logic [NBITS-1:0]   sum;
    logic               overflow;
    logic               cout_unused;
    logic [NBITS-1:0]   sel;
    logic               sign;
    logic [NBITS-1:0]   next_acc;
    logic [NBITS-1:0]   next_q;

    sumadorRestadorNBits #(
        .NBITS(NBITS)
    ) u_sumador (
        .iX       (acc),
        .iY       (mcand),
        .iOp      (do_sub),
        .oS       (sum),
        .oCout    (cout_unused),
        .oOverflow(overflow)
    );

    assign pair      = {mult_q[0], q_m1};
    assign do_sub    = (pair == PAIR_SUB);
    assign use_adder = (pair == PAIR_ADD) || (pair == PAIR_SUB);
    assign sel       = use_adder ? sum : acc;

    // The shifted-in sign must be the true sign: subtracting the most negative value overflows.
    assign sign      = use_adder ? (sum[NBITS-1] ^ overflow) : acc[NBITS-1];
    assign next_acc  = {sign, sel[NBITS-1:1]};
    assign next_q    = {sel[0], mult_q[NBITS-1:1]};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            acc     <= '0;
            mult_q  <= '0;
            mcand   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (iStart) begin
                        mcand  <= iMultiplicando;
                        mult_q <= iMultiplicador;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        count  <= CW'(NBITS);
                        state  <= CALC;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    acc    <= next_acc;
                    mult_q <= next_q;
                    q_m1   <= mult_q[0];
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= {next_acc, next_q};
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (iStart) begin
                        mcand  <= iMultiplicando;
                        mult_q <= iMultiplicador;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        count  <= CW'(NBITS);
                        state  <= CALC;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign oProducto = product;
    assign oBusy     = busy;
    assign oDone     = done;

endmodule

// File: tb/tb_multiplicador_booth_nbits.sv
// Self-checking bench: directed corners, reset abort and random back-to-back products vs integer math.
module tb_multiplicador_booth_nbits;

    localparam int NBITS = 8;
    localparam int NB2B  = 200;

    logic               iClk;
    logic               iRst;
    logic               iStart;
    logic [NBITS-1:0]   iMultiplicando;
    logic [NBITS-1:0]   iMultiplicador;
    logic [2*NBITS-1:0] oProducto;
    logic               oBusy;
    logic               oDone;

    int checks = 0;
    int fails  = 0;

    logic [NBITS-1:0] opA [NB2B];
    logic [NBITS-1:0] opB [NB2B];

    multiplicador_booth_nbits #(
        .NBITS(NBITS)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iStart        (iStart),
        .iMultiplicando(iMultiplicando),
        .iMultiplicador(iMultiplicador),
        .oProducto     (oProducto),
        .oBusy         (oBusy),
        .oDone         (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference product from plain signed integer arithmetic.
    function automatic logic [2*NBITS-1:0] refProduct(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        int x;
        int y;
        int p;
        x = int'($signed(a));
        y = int'($signed(b));
        p = x * y;
        return p[2*NBITS-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // One isolated operation; optionally pulses iStart mid-calculation, which must be ignored.
    task automatic applyStimulus(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input bit pokeStart);
        int edges;
        int busyCycles;
        bit found;
        iMultiplicando = a;
        iMultiplicador = b;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iMultiplicando = NBITS'($urandom);
        iMultiplicador = NBITS'($urandom);
        edges = 1;
        busyCycles = 0;
        found = 1'b0;
        while (!found && edges < 40) begin
            if (oDone) begin
                found = 1'b1;
            end else begin
                if (oBusy) busyCycles++;
                iStart = (pokeStart && edges == 3);
                tick();
                edges++;
            end
        end
        iStart = 1'b0;
        checkOutput("done_seen", 32'(found), 32'd1);
        checkOutput("latency", 32'(edges), 32'(NBITS + 1));
        checkOutput("busy_cycles", 32'(busyCycles), 32'(NBITS));
        checkOutput("product", 32'(oProducto), 32'(refProduct(a, b)));
        checkOutput("busy_at_done", 32'(oBusy), 32'd0);
        tick();
        checkOutput("done_width", 32'(oDone), 32'd0);
        checkOutput("product_hold", 32'(oProducto), 32'(refProduct(a, b)));
    endtask

    initial begin
        int edges;
        int doneCount;
        iRst = 1'b1;
        iStart = 1'b0;
        iMultiplicando = '0;
        iMultiplicador = '0;
        tick();
        tick();
        checkOutput("reset_product", 32'(oProducto), 32'd0);
        checkOutput("reset_busy", 32'(oBusy), 32'd0);
        checkOutput("reset_done", 32'(oDone), 32'd0);
        iRst = 1'b0;
        tick();

        applyStimulus(8'h03, 8'h05, 1'b0);
        applyStimulus(8'hFD, 8'h05, 1'b1);
        applyStimulus(8'h07, 8'hFF, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        applyStimulus(8'h80, 8'h7F, 1'b1);
        applyStimulus(8'h00, 8'hB3, 1'b0);
        applyStimulus(8'h7F, 8'h80, 1'b0);

        // Abort mid-calculation: previous product is cleared and no done pulse follows.
        iMultiplicando = 8'h09;
        iMultiplicador = 8'h0B;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        tick();
        tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checkOutput("abort_product", 32'(oProducto), 32'd0);
        checkOutput("abort_busy", 32'(oBusy), 32'd0);
        checkOutput("abort_done", 32'(oDone), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (oDone) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        applyStimulus(8'h06, 8'h07, 1'b0);

        // Back-to-back with iStart held high; operands for the next op are presented during CALC.
        opA[0] = 8'h02; opB[0] = 8'h03;
        opA[1] = 8'h04; opB[1] = 8'h05;
        opA[2] = 8'h80; opB[2] = 8'h80;
        opA[3] = 8'h80; opB[3] = 8'h01;
        opA[4] = 8'h01; opB[4] = 8'h80;
        opA[5] = 8'hFF; opB[5] = 8'hFF;
        for (int i = 6; i < NB2B; i++) begin
            opA[i] = NBITS'($urandom);
            opB[i] = NBITS'($urandom);
        end
        iMultiplicando = opA[0];
        iMultiplicador = opB[0];
        iStart = 1'b1;
        tick();
        checkOutput("b2b_busy_start", 32'(oBusy), 32'd1);
        iMultiplicando = opA[1];
        iMultiplicador = opB[1];
        for (int i = 0; i < NB2B; i++) begin
            edges = 1;
            while (!oDone && edges < 40) begin
                tick();
                edges++;
            end
            checkOutput("b2b_latency", 32'(edges), 32'(NBITS + 1));
            checkOutput("b2b_product", 32'(oProducto), 32'(refProduct(opA[i], opB[i])));
            if (i == NB2B - 1) iStart = 1'b0;
            tick();
            if (i < NB2B - 1) begin
                checkOutput("b2b_busy_next", 32'(oBusy), 32'd1);
                checkOutput("b2b_hold", 32'(oProducto), 32'(refProduct(opA[i], opB[i])));
            end
            if (i + 2 < NB2B) begin
                iMultiplicando = opA[i+2];
                iMultiplicador = opB[i+2];
            end
        end
        checkOutput("final_busy", 32'(oBusy), 32'd0);
        checkOutput("final_done", 32'(oDone), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
